// File: rtl/alu_ops_pkg.sv
// ALU-wide operation codes and the shared sequencing encoding used by the multi-cycle shifter.
// Contents: opcode constants (ADD/SUB/AND/OR/SLT/SLL/DIVU/SRL/SRA), shift-amount width,
//           the IDLE/SHIFT/DONE state type and an opcode classifier for the right shifter.
package alu_ops_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  // Shift amounts are always taken from inputB[4:0].
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic is_shift_right(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_right_step.sv
// Combinational right shift by k with a selectable fill bit; one slice of the iterative shifter.
// Latency: none (pure combinational). Backpressure: none.
// Ports: din (value), k (bits to shift, caller limits it to 0..STEP), fill (vacated-bit value), dout.
module shift_right_step
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] k,
  input  logic               fill,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] fill_mask;

  // Ones in exactly the k vacated MSB positions.
  assign fill_mask = ~({WIDTH{1'b1}} >> k);
  assign dout      = (din >> k) | (fill ? fill_mask : '0);

endmodule

// File: rtl/shifter_right_seq.sv
// Multi-cycle SRL/SRA: shifts inputA right by inputB[4:0], at most STEP bits per clock.
// Latency: done in the cycle after edge ceil(amt/STEP)+1 (1 edge for amt==0 or unsupported op).
// Backpressure: start is only sampled in IDLE; starts during SHIFT/DONE are dropped, not queued.
// Ports: clk, reset (async, active-high), start, SignalIn (opcode), inputA, inputB,
//        busy (operation in flight), done (1-cycle result pulse), out (held result register).
module shifter_right_seq
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       SignalIn,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     operand;
  logic [WIDTH-1:0]     step_out;
  logic [SHAMT_W-1:0]   remaining;
  logic [SHAMT_W-1:0]   rem_nxt;
  logic [SHAMT_W-1:0]   k;
  logic [SHAMT_W-1:0]   amt;
  logic                 arith;
  logic                 valid;
  logic                 fill;
  logic                 unused_b;

  assign amt      = inputB[SHAMT_W-1:0];
  assign unused_b = ^inputB[WIDTH-1:SHAMT_W];
  assign valid    = is_shift_right(SignalIn);

  // Last slice may be shorter than STEP so the total shift is exact.
  assign k       = (remaining < STEP_K) ? remaining : STEP_K;
  assign rem_nxt = remaining - k;
  assign fill    = arith & operand[WIDTH-1];

  shift_right_step #(.WIDTH(WIDTH)) u_step (
    .din  (operand),
    .k    (k),
    .fill (fill),
    .dout (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (valid && (amt != '0)) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (rem_nxt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand   <= '0;
      remaining <= '0;
      arith     <= 1'b0;
      out       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            operand   <= inputA;
            remaining <= amt;
            arith     <= (SignalIn == OP_SRA);
            // Operations that skip SHIFT resolve their result right here.
            if (!valid)           out <= WIDTH'(1);
            else if (amt == '0)   out <= inputA;
          end
        end
        ST_SHIFT: begin
          operand   <= step_out;
          remaining <= rem_nxt;
          if (rem_nxt == '0) out <= step_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_right_seq.sv
module tb_shifter_right_seq;
  import alu_ops_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [3:0]  SignalIn;
  logic [31:0] inputA, inputB;
  logic        busy1, done1, busy4, done4;
  logic [31:0] out1, out4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shifter_right_seq #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .SignalIn(SignalIn),
    .inputA(inputA), .inputB(inputB), .busy(busy1), .done(done1), .out(out1)
  );

  shifter_right_seq #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .SignalIn(SignalIn),
    .inputA(inputA), .inputB(inputB), .busy(busy4), .done(done4), .out(out4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_out(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] amt;
    amt = b[4:0];
    if (op == OP_SRA) return $unsigned($signed(a) >>> amt);
    if (op == OP_SRL) return a >> amt;
    return 32'h0000_0001;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b, input int step);
    int amt;
    amt = int'(b[4:0]);
    if ((op != OP_SRL && op != OP_SRA) || amt == 0) return 1;
    return (amt + step - 1) / step + 1;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done4 : done1;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? busy4 : busy1;
  endfunction

  function automatic logic [31:0] cur_out(input bit sel);
    return sel ? out4 : out1;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  // Drives one operation, then waits (bounded) for done and scores it.
  // poke_at > 0 re-raises start for one cycle at that edge, while the DUT is busy.
  task automatic run_op(input string tag, input bit sel, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int poke_at);
    exp_t e;
    exp_t got;
    int   edges;
    int   extra;
    e.res = exp_res;
    e.lat = exp_lat;
    sb.push_back(e);
    SignalIn = op;
    inputA   = a;
    inputB   = b;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    edges = 1;
    // Operation in flight must not see later input changes.
    SignalIn = OP_ADD;
    inputA   = ~a;
    inputB   = b ^ 32'h0000_0015;
    check({tag, "_busy"}, {31'b0, cur_busy(sel)}, 32'd1);
    while (!cur_done(sel) && edges < 100) begin
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      edges++;
      if (edges == poke_at) set_start(sel, 1'b1);
    end
    if (!cur_done(sel)) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check({tag, "_out"}, cur_out(sel), got.res);
      check({tag, "_lat"}, edges, got.lat);
      @(posedge clk); #1;
      check({tag, "_pulse"}, {30'b0, cur_done(sel), cur_busy(sel)}, 32'd0);
      check({tag, "_hold"}, cur_out(sel), got.res);
      if (poke_at > 0) begin
        extra = 0;
        repeat (40) begin
          @(posedge clk); #1;
          if (cur_done(sel)) extra++;
        end
        check({tag, "_extra_done"}, extra, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [3:0]  op;
    logic [31:0] a, b;
    bit sel;

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    SignalIn = OP_ADD; inputA = '0; inputB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_u1", {out1[29:0], busy1, done1}, 32'd0);
    check("rst_out1", out1, 32'd0);
    check("rst_u4", {out4[29:0], busy4, done4}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("srl31",      0, OP_SRL, 32'h8000_0000, 32'd31,        32'h0000_0001, 32, 0);
    run_op("sra4",       0, OP_SRA, 32'h8000_0000, 32'd4,         32'hF800_0000, 5,  0);
    run_op("sra7_s4",    1, OP_SRA, 32'h8000_0000, 32'd7,         32'hFF00_0000, 3,  0);
    run_op("amt0",       0, OP_SRL, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1,  0);
    run_op("amt0_s4",    1, OP_SRA, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321, 1,  0);
    run_op("add",        0, OP_ADD, 32'hDEAD_BEEF, 32'd3,         32'h0000_0001, 1,  0);
    run_op("sra31_s4",   1, OP_SRA, 32'h8000_0001, 32'd31,        32'hFFFF_FFFF, 9,  0);
    run_op("srl31_s4",   1, OP_SRL, 32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 9,  0);
    run_op("ignore",     0, OP_SRL, 32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 32, 6);

    // Abort mid-shift: everything clears at once, no done for the lost operation.
    SignalIn = OP_SRA; inputA = 32'hF000_0000; inputB = 32'd20;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", {31'b0, busy1}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_out", out1, 32'd0);
    check("abort_ctl", {30'b0, busy1, done1}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done1) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("after_rst", 0, OP_SRL, 32'h0000_0002, 32'd1, 32'h0000_0001, 2, 0);

    for (int i = 0; i < 10; i++) begin
      sel = (i % 2) == 1;
      case ($urandom_range(0, 3))
        0:       op = OP_SRL;
        1:       op = OP_SRA;
        2:       op = OP_SLL;
        default: op = OP_SRA;
      endcase
      a = $urandom;
      b = $urandom;
      run_op($sformatf("rnd%0d", i), sel, op, a, b,
             model_out(op, a, b), model_lat(op, b, sel ? 4 : 1), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter_right_seq.md
Name: shifter_right_seq

Overview:
- Multi-cycle logical/arithmetic right shifter for the ALU; the counterpart of the existing single-cycle left shifter (SLL).
- Shifts inputA right by inputB[4:0] at STEP bits per clock, under a start/busy/done handshake.
- Sits beside the ALU datapath. The pipeline stalls on busy and takes the result when done pulses.

Parameters:
- WIDTH, 32, datapath width. The shift amount is always inputB[4:0].
- STEP, 1, maximum bits shifted per cycle. Legal values are 1, 2, 4, 8 and 16.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- SignalIn  in  4  ALU operation code; SRL=4'b1000, SRA=4'b1001
- inputA  in  WIDTH  value to shift
- inputB  in  WIDTH  shift amount source; only bits [4:0] are used
- busy  out  1  high from the cycle after an accepted start until done has been issued
- done  out  1  one-cycle pulse when out holds a new result
- out  out  WIDTH  result register; holds its value between operations

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, busy=0, done=0, out=32'h0.
  - All internal registers (operand, remaining count, arith flag) are 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - A start sampled high on an edge latches inputA, amt=inputB[4:0], arith=(SignalIn==SRA) and valid=(SignalIn is SRL or SRA).
  - Next state is SHIFT if valid and amt!=0; otherwise DONE.
- SHIFT, per edge:
  - k = min(remaining, STEP).
  - operand shifts right by k, filled with operand[MSB] if arith, else 0.
  - remaining decrements by k.
  - When remaining reaches 0, the state moves to DONE and out takes the final operand.
- Entering DONE directly from IDLE:
  - If valid and amt==0, out = inputA unchanged.
  - If not valid, out = 32'h0000_0001, matching the ALU default for unsupported codes.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. busy=0 in IDLE.
- Latency: done is high in the cycle following edge number (ceil(amt/STEP)+1), counting the start-sampling edge as edge 1.
  - With STEP=1 and amt=31, that is 32 edges.
  - amt=0 or an invalid opcode takes 1 edge.
- start while busy (SHIFT or DONE) is ignored, with no queuing. start is level-sampled, so a start held high in IDLE immediately after DONE begins a new operation.
- Changes to inputA, inputB or SignalIn after the start edge have no effect on the operation in flight.
- Reset mid-operation:
  - Immediate return to IDLE, out=0, done=0.
  - No done is issued for the aborted operation.
- Arithmetic rules:
  - SRA of a negative value by 31 gives 32'hFFFF_FFFF.
  - SRL by 31 leaves only bit 0 = old bit 31.
  - The shift amount never exceeds 31, so there is no overflow case.

Decomposition:
- Shared package/include alu_ops: all ALU operation constants (ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, SLL 0011, DIVU 0100, SRL 1000, SRA 1001) and the 2-bit state encoding for IDLE, SHIFT and DONE.
- One sub-module, shift_right_step: combinational right shift by k (0..STEP) with a fill-bit input, instantiated once in the SHIFT datapath.

Test Plan:
1. STEP=1, SRL, inputA=32'h8000_0000, inputB=31 -> busy for 31 SHIFT cycles, done on edge 32, out=32'h0000_0001.
2. STEP=1, SRA, inputA=32'h8000_0000, inputB=4 -> done on edge 5, out=32'hF800_0000. Repeat with STEP=4 and inputB=7 -> done on edge 3, out=32'hFF00_0000.
3. SRL, inputA=32'h1234_5678, inputB=32'hFFFF_FFE0 (amt=0) -> done on edge 1, out=32'h1234_5678.
4. SignalIn=ADD with start -> done on edge 1, out=32'h0000_0001. A second start pulsed during SHIFT of a 31-bit shift is ignored: exactly one done, result from the first operation.
5. Assert reset during SHIFT of SRA 32'hF000_0000 by 20 -> out=0, busy=0 immediately, no done. After release, a new SRL by 1 of 32'h2 gives out=32'h1.
